pt_write_port: RTL and testbench

PT_WRITE_PORT -- requirements
Module: pt_write_port

---
 rtl/pt_write_port.sv | 209 ++++++++++++++++++++
 tb/tb_pt_write_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pt_write_port.sv
`default_nettype none
// ============================================================================
//  Module   : pt_write_port
//  Purpose  : Buffers transformed pixels and packs horizontally adjacent
//             pairs into 36-bit frame-buffer words for the memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module pt_write_port #(
    parameter int          DEPTH         = 8,
    parameter logic [18:0] FRAME_BASE    = 19'h00000,
    parameter int          FLUSH_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [17:0]              pt_pixel_write,
    input  logic [9:0]               pt_x,
    input  logic [8:0]               pt_y,
    input  logic                     pt_wr,
    output logic                     ptflag,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [18:0]              mem_addr,
    output logic [35:0]              mem_wdata,
    output logic [1:0]               mem_be,
    input  logic                     mem_grant,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_ww = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [c_cw-1:0] c_depth      = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_ptflag_max = c_cw'(DEPTH - 3);
    localparam logic [c_ww:0]   c_timeout    = (c_ww + 1)'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    // Entry layout: {y[36:28], x[27:18], pixel[17:0]}
    logic [36:0]        fifo_mem [DEPTH];

    state_t             state_q,      state_d;
    logic [c_aw-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [c_aw-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [c_cw-1:0]    fifo_count_q, fifo_count_d;
    logic [c_ww-1:0]    wait_cnt_q,   wait_cnt_d;
    logic               flush_q,      flush_d;
    logic               overflow_q,   overflow_d;
    logic               ptflag_q,     ptflag_d;
    logic               mem_req_q,    mem_req_d;
    logic [18:0]        mem_addr_q,   mem_addr_d;
    logic [35:0]        mem_wdata_q,  mem_wdata_d;
    logic [1:0]         mem_be_q,     mem_be_d;
    logic               pop_two_q,    pop_two_d;

    logic [36:0]        w_head;
    logic [36:0]        w_next;
    logic               w_push;
    logic               w_drop;
    logic               w_partner;
    logic               w_lone_even;
    logic               w_force;
    logic               w_ready;
    logic               w_pop_two;
    logic [1:0]         w_be;
    logic [35:0]        w_wdata;
    logic [18:0]        w_addr;
    logic [1:0]         w_pop;

    always_comb begin
        w_head      = fifo_mem[rd_ptr_q];
        w_next      = fifo_mem[rd_ptr_q + 1'b1];
        w_push      = pt_wr && (fifo_count_q != c_depth);
        w_drop      = pt_wr && (fifo_count_q == c_depth);
        w_partner   = (fifo_count_q >= c_cw'(2))
                      && (w_next[36:28] == w_head[36:28])
                      && (w_next[27:18] == (w_head[27:18] + 10'd1));
        w_lone_even = (fifo_count_q == c_cw'(1)) && !w_head[18];
        // The current waiting cycle counts toward the timeout, so the word is
        // decided on the FLUSH_TIMEOUT-th waiting cycle.
        w_force     = flush_q || flush
                      || (({1'b0, wait_cnt_q} + 1'b1) >= c_timeout);

        w_ready   = 1'b0;
        w_pop_two = 1'b0;
        w_be      = 2'b00;
        w_wdata   = 36'd0;
        if (fifo_count_q != '0) begin
            if (w_head[18]) begin
                w_ready = 1'b1;
                w_be    = 2'b01;
                w_wdata = {18'd0, w_head[17:0]};
            end else if (w_partner) begin
                w_ready   = 1'b1;
                w_pop_two = 1'b1;
                w_be      = 2'b11;
                w_wdata   = {w_head[17:0], w_next[17:0]};
            end else if (!w_lone_even || w_force) begin
                w_ready = 1'b1;
                w_be    = 2'b10;
                w_wdata = {w_head[17:0], 18'd0};
            end
        end

        // y*320 = (y<<8) + (y<<6), wrapped to the 19-bit word space
        w_addr = FRAME_BASE
                 + ({10'd0, w_head[36:28]} << 8)
                 + ({10'd0, w_head[36:28]} << 6)
                 + {10'd0, w_head[27:19]};
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        pop_two_d   = pop_two_q;
        w_pop       = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (w_ready) begin
                    state_d     = S_PRESENT;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = w_addr;
                    mem_wdata_d = w_wdata;
                    mem_be_d    = w_be;
                    pop_two_d   = w_pop_two;
                end
            end
            S_PRESENT: begin
                if (mem_grant) begin
                    w_pop     = pop_two_q ? 2'd2 : 2'd1;
                    state_d   = S_GAP;
                    mem_req_d = 1'b0;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_IDLE) && w_lone_even && !w_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end

        rd_ptr_d     = rd_ptr_q + c_aw'(w_pop);
        wr_ptr_d     = wr_ptr_q + c_aw'(w_push);
        fifo_count_d = fifo_count_q + c_cw'(w_push) - c_cw'(w_pop);
        overflow_d   = overflow_q || w_drop;
        ptflag_d     = (fifo_count_d <= c_ptflag_max);
        flush_d      = (flush_q || flush) && (fifo_count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= {pt_y, pt_x, pt_pixel_write};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_count_q <= '0;
            wait_cnt_q   <= '0;
            flush_q      <= 1'b0;
            overflow_q   <= 1'b0;
            ptflag_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            pop_two_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_count_q <= fifo_count_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_q      <= flush_d;
            overflow_q   <= overflow_d;
            ptflag_q     <= ptflag_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            pop_two_q    <= pop_two_d;
        end
    end

    assign ptflag     = ptflag_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign fifo_count = fifo_count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pt_write_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pt_write_port
//  Purpose  : Directed self-checking bench for pt_write_port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pt_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] pt_pixel_write;
    logic [9:0]  pt_x;
    logic [8:0]  pt_y;
    logic        pt_wr;
    logic        ptflag;
    logic        flush;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [35:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_grant;
    logic [3:0]  fifo_count;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    localparam logic [17:0] PA = 18'h2AAAA;
    localparam logic [17:0] PB = 18'h15555;
    localparam logic [17:0] PC = 18'h0C0DE;
    localparam logic [17:0] PD = 18'h3D00D;
    localparam logic [17:0] PE = 18'h0EEEE;
    localparam logic [17:0] PF = 18'h0F0F0;
    localparam logic [17:0] PH = 18'h12345;

    pt_write_port dut (
        .clk            (clk),
        .reset          (reset),
        .pt_pixel_write (pt_pixel_write),
        .pt_x           (pt_x),
        .pt_y           (pt_y),
        .pt_wr          (pt_wr),
        .ptflag         (ptflag),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_grant      (mem_grant),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] x, input logic [8:0] y, input logic [17:0] pix);
        pt_x           = x;
        pt_y           = y;
        pt_pixel_write = pix;
        pt_wr          = 1'b1;
        tick();
        pt_wr          = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [18:0] addr,
                              input logic [35:0] wdata, input logic [1:0] be);
        check({tag, "_req"},   mem_req,   1);
        check({tag, "_addr"},  mem_addr,  addr);
        check({tag, "_wdata"}, mem_wdata, wdata);
        check({tag, "_be"},    mem_be,    be);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [57:0] stall_exp;

        reset = 1'b1; pt_wr = 1'b0; flush = 1'b0; mem_grant = 1'b0;
        pt_x = '0; pt_y = '0; pt_pixel_write = '0;
        tick(); tick();
        check("rst_req",      mem_req,    0);
        check("rst_count",    fifo_count, 0);
        check("rst_overflow", overflow,   0);
        check("rst_ptflag",   ptflag,     0);
        check("rst_be",       mem_be,     0);
        reset = 1'b0;
        tick();
        check("rst_ptflag_rise", ptflag, 1);

        // Adjacent pair
        push(10'd4, 9'd2, PA);
        push(10'd5, 9'd2, PB);
        tick();
        check_word("pair", 19'd642, {PA, PB}, 2'b11);
        check("pair_count", fifo_count, 2);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("pair_req_fall", mem_req,    0);
        check("pair_count0",   fifo_count, 0);
        tick();

        // Odd head alone
        push(10'd7, 9'd0, PC);
        tick();
        check_word("odd", 19'd3, {18'd0, PC}, 2'b01);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("odd_count0", fifo_count, 0);
        tick();

        // Lone even pixel released by timeout
        push(10'd10, 9'd1, PD);
        repeat (14) tick();
        check("lone_wait15", mem_req, 0);
        tick();
        check_word("lone_tmo", 19'd325, {PD, 18'd0}, 2'b10);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("lone_count0", fifo_count, 0);
        tick();

        // Lone even pixel released by flush in waiting cycle 3
        push(10'd10, 9'd1, PD);
        tick(); tick();
        flush = 1'b1;
        check("flush_wait3", mem_req, 0);
        tick();
        flush = 1'b0;
        check_word("flush", 19'd325, {PD, 18'd0}, 2'b10);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("flush_count0", fifo_count, 0);
        tick();

        // Even head followed by a non-partner, then the odd pixel
        push(10'd2, 9'd0, PE);
        push(10'd9, 9'd3, PF);
        tick();
        check_word("nonpart_e", 19'd1, {PE, 18'd0}, 2'b10);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("nonpart_gap_req", mem_req,    0);
        check("nonpart_count1",  fifo_count, 1);
        tick();
        check("nonpart_idle_req", mem_req, 0);
        tick();
        check_word("nonpart_f", 19'd964, {18'd0, PF}, 2'b01);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("nonpart_count0", fifo_count, 0);
        tick();

        // Stall 20 cycles in PRESENT with a push arriving mid-stall
        push(10'd7, 9'd0, PC);
        tick();
        stall_exp = {1'b1, 2'b01, 19'd3, 18'd0, PC};
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                pt_x = 10'd8; pt_y = 9'd0; pt_pixel_write = PH; pt_wr = 1'b1;
            end
            tick();
            pt_wr = 1'b0;
            check("stall_word", {mem_req, mem_be, mem_addr, mem_wdata}, stall_exp);
        end
        check("stall_count2", fifo_count, 2);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("stall_req_fall", mem_req,    0);
        check("stall_count1",   fifo_count, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_word("stall_h", 19'd4, {PH, 18'd0}, 2'b10);
        mem_grant = 1'b1; tick(); mem_grant = 1'b0;
        check("stall_count0", fifo_count, 0);
        tick();

        // Backpressure and overflow with grant held low
        for (int k = 1; k <= 8; k++) begin
            push(10'(2 * k - 1), 9'd5, 18'(18'h100 + k));
            check("bp_count",  fifo_count, k);
            check("bp_ptflag", ptflag,     (k <= 5) ? 1 : 0);
        end
        check("bp_no_ovf", overflow, 0);
        push(10'd17, 9'd5, 18'h3FFFF);
        check("bp_ovf",      overflow,   1);
        check("bp_count8",   fifo_count, 8);
        check_word("bp_head", 19'd1600, {18'd0, 18'h00101}, 2'b01);
        tick(); tick();
        check("bp_ovf_sticky", overflow, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("bp_rst_count", fifo_count, 0);
        check("bp_rst_ovf",   overflow,   0);
        tick();

        // Reset while presenting with three entries queued
        push(10'd1, 9'd0, PA);
        push(10'd3, 9'd0, PB);
        push(10'd5, 9'd0, PC);
        check("rp_req",   mem_req,    1);
        check("rp_count", fifo_count, 3);
        reset = 1'b1; tick();
        check("rp_rst_req",    mem_req,    0);
        check("rp_rst_count",  fifo_count, 0);
        check("rp_rst_ptflag", ptflag,     0);
        reset = 1'b0; tick();
        check("rp_ptflag", ptflag,  1);
        check("rp_req_lo", mem_req, 0);
        push(10'd11, 9'd479, PF);
        tick();
        check_word("rp_after", 19'd153285, {18'd0, PF}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
